// File: rtl/seg7_pkg.sv
// Shared types and glyph helpers for the multiplexed seven-segment scan engine.
package seg7_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    STORE = 2'd3
  } conv_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low glyphs, bit0 = segment a ... bit6 = segment g.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3), one bit per shift cycle.
// A load in hex mode produces the nibble digits directly, with no shifting needed.
module bin2bcd_seq #(
  parameter int W   = 8,
  parameter int DPC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic             hex_i,
  input  logic [W-1:0]     value_i,
  output logic [4*DPC-1:0] digits_o,
  output logic             ovf_o
);
  localparam int BW = 4 * DPC;

  logic [W-1:0]    bin_q, bin_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   adj;
  logic [W+BW-1:0] wide;

  always_comb begin
    wide = {{BW{1'b0}}, value_i};
    adj  = bcd_q;
    for (int i = 0; i < DPC; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    bin_d = bin_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    if (load_i) begin
      bin_d = value_i;
      bcd_d = hex_i ? wide[BW-1:0] : '0;
      ovf_d = hex_i & (|wide[W+BW-1:BW]);
    end else if (shift_i) begin
      bin_d = bin_q << 1;
      bcd_d = {adj[BW-2:0], bin_q[W-1]};
      // A carry out of the top digit means the value needs more digits than we have.
      ovf_d = ovf_q | adj[BW-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
    end
  end

  assign digits_o = bcd_q;
  assign ovf_o    = ovf_q;

endmodule

// File: rtl/seg7_scan_engine.sv
// Multi-channel seven-segment driver: snapshots values, converts them per channel into
// display banks, and time-multiplexes the digits with a prescaled scan counter.
module seg7_scan_engine
  import seg7_pkg::*;
#(
  parameter int W           = 8,
  parameter int N_CH        = 2,
  parameter int DPC         = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                 clk,
  input  logic                 CLEARn,
  input  logic [N_CH*W-1:0]    vals,
  input  logic                 upd,
  input  logic                 hex_mode,
  input  logic                 blank_lz,
  input  logic [N_CH*DPC-1:0]  dp_mask,
  output logic [N_CH*DPC-1:0]  an,
  output logic [6:0]           g_to_a,
  output logic                 dp,
  output logic                 busy,
  output logic                 done,
  output logic [N_CH-1:0]      ovf
);
  localparam int ND  = N_CH * DPC;
  localparam int BW  = 4 * DPC;
  localparam int CHW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int BCW = $clog2(W + 1);
  localparam int PW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW  = (ND > 1) ? $clog2(ND) : 1;
  localparam int PSW = (DPC > 1) ? $clog2(DPC) : 1;

  conv_state_e                state_q;
  logic [CHW-1:0]             ch_q;
  logic [BCW-1:0]             bit_cnt_q;
  logic [N_CH*W-1:0]          snap_vals_q;
  logic                       snap_hex_q;
  logic                       busy_q;
  logic                       done_q;
  logic [N_CH-1:0][BW-1:0]    bank_q;
  logic [N_CH-1:0]            ovf_q;

  logic                       conv_load;
  logic                       conv_shift;
  logic [W-1:0]               conv_value;
  logic [BW-1:0]              conv_digits;
  logic                       conv_ovf;

  assign conv_load  = (state_q == LOAD);
  assign conv_shift = (state_q == SHIFT);
  assign conv_value = snap_vals_q[ch_q*W +: W];

  bin2bcd_seq #(
    .W   (W),
    .DPC (DPC)
  ) u_conv (
    .clk      (clk),
    .rst_n    (CLEARn),
    .load_i   (conv_load),
    .shift_i  (conv_shift),
    .hex_i    (snap_hex_q),
    .value_i  (conv_value),
    .digits_o (conv_digits),
    .ovf_o    (conv_ovf)
  );

  always_ff @(posedge clk or negedge CLEARn) begin
    if (!CLEARn) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      bit_cnt_q   <= '0;
      snap_vals_q <= '0;
      snap_hex_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bank_q      <= '0;
      ovf_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (upd) begin
            snap_vals_q <= vals;
            snap_hex_q  <= hex_mode;
            ch_q        <= '0;
            busy_q      <= 1'b1;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          bit_cnt_q <= '0;
          state_q   <= snap_hex_q ? STORE : SHIFT;
        end
        SHIFT: begin
          bit_cnt_q <= bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(W - 1)) state_q <= STORE;
        end
        STORE: begin
          bank_q[ch_q] <= conv_digits;
          ovf_q[ch_q]  <= conv_ovf;
          if (ch_q == CHW'(N_CH - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= LOAD;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [PW-1:0]  pre_q;
  logic [IW-1:0]  idx_q;
  logic [ND-1:0]  an_q;
  logic [6:0]     seg_q;
  logic           dp_q;

  logic [CHW-1:0] sel_ch;
  logic [PSW-1:0] sel_pos;
  logic [BW-1:0]  sel_digits;
  logic [BW-1:0]  upper;
  logic           lz_blank;
  logic [6:0]     seg_d;

  // upper holds the selected digit and everything above it, so a zero there means
  // this digit is a leading zero.
  always_comb begin
    sel_ch     = CHW'(idx_q / DPC);
    sel_pos    = PSW'(idx_q % DPC);
    sel_digits = bank_q[sel_ch];
    upper      = sel_digits >> {sel_pos, 2'b00};
    lz_blank   = blank_lz && (sel_pos != '0) && (upper == '0);
    if (ovf_q[sel_ch])  seg_d = SEG_DASH;
    else if (lz_blank)  seg_d = SEG_BLANK;
    else                seg_d = hex_to_seg(upper[3:0]);
  end

  always_ff @(posedge clk or negedge CLEARn) begin
    if (!CLEARn) begin
      pre_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      if (pre_q == PW'(REFRESH_DIV - 1)) begin
        pre_q <= '0;
        idx_q <= (idx_q == IW'(ND - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
      an_q  <= ~(ND'(1) << idx_q);
      seg_q <= seg_d;
      dp_q  <= ~dp_mask[idx_q];
    end
  end

  assign an     = an_q;
  assign g_to_a = seg_q;
  assign dp     = dp_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_seg7_scan_engine.sv
// Directed and randomized checks of the scan engine against an arithmetic display model.
module tb_seg7_scan_engine;
  localparam int W = 8, N_CH = 2, DPC = 4, RD = 4, ND = 8;

  logic        clk = 1'b0;
  logic        CLEARn;
  logic [15:0] vals;
  logic        upd, hex_mode, blank_lz;
  logic [7:0]  dp_mask;
  logic [7:0]  an;
  logic [6:0]  g_to_a;
  logic        dp, busy, done;
  logic [1:0]  ovf;

  logic [15:0] vals2;
  logic        upd2, hex2, blz2;
  logic [3:0]  dpm2;
  logic [3:0]  an2;
  logic [6:0]  g2;
  logic        dp2, busy2, done2;
  logic [1:0]  ovf2;

  int tests = 0;
  int fails = 0;
  int mv[2];
  bit mhex;

  always #5 clk = ~clk;

  seg7_scan_engine #(.W(W), .N_CH(N_CH), .DPC(DPC), .REFRESH_DIV(RD)) dut (
    .clk(clk), .CLEARn(CLEARn), .vals(vals), .upd(upd), .hex_mode(hex_mode),
    .blank_lz(blank_lz), .dp_mask(dp_mask), .an(an), .g_to_a(g_to_a), .dp(dp),
    .busy(busy), .done(done), .ovf(ovf)
  );

  seg7_scan_engine #(.W(W), .N_CH(N_CH), .DPC(2), .REFRESH_DIV(RD)) dut2 (
    .clk(clk), .CLEARn(CLEARn), .vals(vals2), .upd(upd2), .hex_mode(hex2),
    .blank_lz(blz2), .dp_mask(dpm2), .an(an2), .g_to_a(g2), .dp(dp2),
    .busy(busy2), .done(done2), .ovf(ovf2)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  function automatic int power(input int base, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * base;
    return r;
  endfunction

  function automatic bit exp_ovf(input int v, input bit hexm, input int dpc);
    return v >= power(hexm ? 16 : 10, dpc);
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input bit hexm, input int dpc,
                                         input int pos, input bit blz);
    int base, p;
    base = hexm ? 16 : 10;
    if (exp_ovf(v, hexm, dpc)) return 7'h3F;
    p = power(base, pos);
    if (blz && pos != 0 && v / p == 0) return 7'h7F;
    return glyph((v / p) % base);
  endfunction

  task automatic show1();
    logic [7:0] target;
    bit         edp;
    @(negedge clk);
    for (int k = 0; k < ND; k++) begin
      target = ~(8'd1 << k);
      for (int c = 0; c < 100 && an !== target; c++) @(negedge clk);
      check($sformatf("an_reach_%0d", k), an, target);
      check($sformatf("seg_digit%0d", k), g_to_a, exp_seg(mv[k / DPC], mhex, DPC, k % DPC, blank_lz));
      edp = ~dp_mask[k];
      check($sformatf("dp_digit%0d", k), dp, edp);
    end
  endtask

  task automatic frame1(input int v0, input int v1, input bit hexm, input bit pulse_mid);
    int cnt, early;
    @(negedge clk);
    vals = {v1[7:0], v0[7:0]};
    hex_mode = hexm;
    upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
    vals = 16'($urandom);
    hex_mode = ~hexm;
    mv[0] = v0; mv[1] = v1; mhex = hexm;
    cnt = 0; early = 0;
    while (busy === 1'b1 && cnt < 200) begin
      if (done === 1'b1) early++;
      cnt++;
      if (pulse_mid && cnt == 8) upd = 1'b1;
      if (cnt == 9) upd = 1'b0;
      @(posedge clk); #1;
    end
    check("busy_len", cnt, hexm ? 2 * N_CH : N_CH * (W + 2));
    check("done_early", early, 0);
    check("done_pulse", done, 1);
    check("ovf", ovf, {exp_ovf(v1, hexm, DPC), exp_ovf(v0, hexm, DPC)});
    @(posedge clk); #1;
    check("done_width", done, 0);
    check("idle_after", busy, 0);
  endtask

  initial begin
    logic [7:0] t8;
    logic [3:0] t4;
    int         cnt, dcnt, v;
    bit         edp;

    vals = '0; upd = 0; hex_mode = 0; blank_lz = 0; dp_mask = '0;
    vals2 = '0; upd2 = 0; hex2 = 0; blz2 = 0; dpm2 = '0;
    mv[0] = 0; mv[1] = 0; mhex = 0;
    CLEARn = 1'b0;
    #12;
    check("rst_an", an, 8'hFF);
    check("rst_seg", g_to_a, 7'h7F);
    check("rst_dp", dp, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_an2", an2, 4'hF);

    @(negedge clk);
    CLEARn = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      t8 = ~(8'd1 << (((e - 1) / RD) % ND));
      check($sformatf("scan_e%0d", e), an, t8);
    end

    blank_lz = 1; dp_mask = 8'h00;
    frame1(7, 255, 0, 1);
    show1();

    blank_lz = 0; dp_mask = 8'hA5;
    frame1(8'hA5, 8'h3C, 1, 0);
    show1();

    blank_lz = 1; dp_mask = 8'h18;
    frame1(0, 8'hF0, 1, 0);
    show1();

    // Narrow instance: three-digit decimal value overflows a two-digit channel.
    blz2 = 1; dpm2 = 4'b0110;
    @(negedge clk);
    vals2 = {8'd45, 8'd123}; upd2 = 1'b1;
    @(posedge clk); #1;
    upd2 = 1'b0; vals2 = '0;
    cnt = 0;
    while (busy2 === 1'b1 && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
    end
    check("dut2_busy_len", cnt, 20);
    check("dut2_done", done2, 1);
    check("dut2_ovf", ovf2, 2'b01);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      t4 = ~(4'd1 << k);
      for (int c = 0; c < 100 && an2 !== t4; c++) @(negedge clk);
      check($sformatf("dut2_an_%0d", k), an2, t4);
      v = (k / 2 == 0) ? 123 : 45;
      check($sformatf("dut2_seg%0d", k), g2, exp_seg(v, 0, 2, k % 2, blz2));
      edp = ~dpm2[k];
      check($sformatf("dut2_dp%0d", k), dp2, edp);
    end

    for (int r = 0; r < 6; r++) begin
      bit hm;
      hm = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      dp_mask = 8'($urandom);
      frame1($urandom_range(0, 255), $urandom_range(0, 255), hm, !hm && ($urandom_range(0, 1) == 1));
      show1();
    end

    // Reset in the middle of a decimal frame.
    @(negedge clk);
    vals = {8'd99, 8'd42}; hex_mode = 0; upd = 1'b1;
    @(posedge clk); #1;
    upd = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    CLEARn = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_an", an, 8'hFF);
    check("midrst_seg", g_to_a, 7'h7F);
    check("midrst_ovf", ovf, 0);
    @(negedge clk);
    CLEARn = 1'b1;
    dcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    check("midrst_no_done", dcnt, 0);
    check("midrst_idle", busy, 0);
    mv[0] = 0; mv[1] = 0; mhex = 0;
    blank_lz = 1;
    show1();

    frame1(200, 9, 0, 0);
    show1();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seg7_scan_engine.md
SEG7_SCAN_ENGINE -- requirements
Module: seg7_scan_engine

Interface
REQ-001 The block SHALL have parameter W, default 8, meaning bit width of each displayed value.
REQ-002 The block SHALL have parameter N_CH, default 2, meaning number of value channels.
REQ-003 The block SHALL have parameter DPC, default 4, meaning digits per channel; ND = N_CH*DPC SHALL be at most 8.
REQ-004 The block SHALL have parameter REFRESH_DIV, default 100000, meaning clock cycles per scanned digit.
REQ-005 The block SHALL have port clk, input, 1, the single system clock.
REQ-006 The block SHALL have port CLEARn, input, 1, the asynchronous active-low reset.
REQ-007 The block SHALL have port vals, input, N_CH*W, packed values with channel 0 in the LSBs.
REQ-008 The block SHALL have port upd, input, 1, a request to snapshot and convert all channels.
REQ-009 The block SHALL have port hex_mode, input, 1: 1 selects hex, 0 selects decimal.
REQ-010 The block SHALL have port blank_lz, input, 1, enabling leading-zero blanking.
REQ-011 The block SHALL have port dp_mask, input, ND, per-digit decimal-point enable.
REQ-012 The block SHALL have port an, output, ND, active-low one-hot digit enable.
REQ-013 The block SHALL have port g_to_a, output, 7, active-low segments with bit0 = a and bit6 = g.
REQ-014 The block SHALL have port dp, output, 1, active-low decimal point.
REQ-015 The block SHALL have port busy, output, 1, high while a conversion frame runs.
REQ-016 The block SHALL have port done, output, 1, a one-cycle pulse when a frame completes.
REQ-017 The block SHALL have port ovf, output, N_CH, per-channel flag indicating the value is not representable.

Function
REQ-018 Converter FSM states SHALL be IDLE, LOAD, SHIFT and STORE; upd sampled high in IDLE SHALL snapshot vals and hex_mode for the whole frame; upd SHALL be ignored while busy.
REQ-019 Per channel (0 upward), the converter SHALL spend 1 LOAD cycle, then W SHIFT cycles in decimal or 0 in hex, then 1 STORE cycle; busy SHALL be high for exactly N_CH*(W+2) cycles in decimal and N_CH*2 in hex.
REQ-020 Decimal conversion SHALL use shift-add-3 into a 4*DPC-bit BCD register; any 1 shifted out of the top digit SHALL set that channel's ovf at STORE.
REQ-021 In hex mode, digit i SHALL be value bits [4i+3:4i], zero-extended; ovf SHALL be set if W > 4*DPC and any bit at or above 4*DPC is 1.
REQ-022 STORE SHALL update the display bank of one channel atomically; displayed digits SHALL change only at STORE.
REQ-023 done SHALL pulse in the first cycle after the last STORE, coincident with busy falling.
REQ-024 The scan prescaler SHALL count 0..REFRESH_DIV-1; at terminal count the digit index SHALL advance 0..ND-1, wrapping to 0.
REQ-025 Digit index k SHALL map to channel k/DPC and position k%DPC, with position 0 least significant.
REQ-026 A digit SHALL be blanked (7'h7F) if blank_lz=1, its value is 0, all higher digits of the channel are 0, and its position is not 0.
REQ-027 A channel with ovf=1 SHALL show a dash (7'h3F) on all of its digits.
REQ-028 Digits with values 0-F SHALL be encoded with standard hex glyphs.
REQ-029 dp SHALL equal ~dp_mask[k].

Reset
REQ-030 CLEARn low SHALL immediately force an=all ones, g_to_a=7'h7F, dp=1, busy=0, done=0, ovf=0, display banks 0, digit index and prescaler 0, and FSM IDLE.
REQ-031 Reset asserted mid-frame SHALL abandon the conversion and produce no done pulse.

Structure
REQ-032 Package seg7_pkg SHALL hold the FSM state enum, the SEG_BLANK and SEG_DASH constants, and the hex-to-segment function.
REQ-033 The iterative converter SHALL be the sub-module bin2bcd_seq.

Verification
(Parameters W=8, N_CH=2, DPC=4, REFRESH_DIV=4.)
REQ-034 Reset -> an=8'hFF, g_to_a=7'h7F, busy=0.
REQ-035 ch0=7, ch1=255, decimal, blank_lz=1, upd -> busy for 20 cycles, then done; digit0 = 7'h78, digits1-3 blank, digits 4-6 show 5,5,2, digit7 blank.
REQ-036 Hex mode, ch0=8'hA5, blank_lz=0 -> busy for 4 cycles; ch0 shows 0,0,A,5.
REQ-037 DPC=2, ch0=123 decimal -> ovf[0]=1; both ch0 digits show 7'h3F.
REQ-038 upd pulsed while busy -> no restart; CLEARn pulsed mid-frame -> busy=0 immediately, no done.
REQ-039 Scan check -> an steps FE, FD, ..., 7F, FE, advancing every 4 cycles.
